re_mapper_gen: RTL and testbench
================================

# re_mapper_gen

Parametrised PUSCH resource-element mapper, the next generation of the uplink RE mapper. It maps a DMRS stream and a data stream (FFT / transform-precoder output) into the frequency grid over a configurable symbol range. The DMRS symbol positions come from a per-slot bitmask, and the DMRS comb offset is selectable. Both input streams use valid/ready handshakes, and the block writes into the grid buffer through a registered write port.

## Interface
Parameters:
- DATA_W, 18, data sample and grid write width (I and Q each)
- DMRS_W, 9, DMRS sample width; sign-extended to DATA_W on output
- MAX_SC, 1200, number of grid subcarriers
- SYM_N, 14, OFDM symbols per slot

Ports (clock and reset first):
- CLK_RE  in  1  single clock; all logic on its rising edge
- RST_RE  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches all cfg inputs
- n_sc  in  11  first allocated subcarrier
- n_rb  in  7  number of allocated RBs
- sym_start, sym_end  in  4 each  first and last symbol, inclusive
- dmrs_mask  in  SYM_N  bit s=1 marks symbol s as a DMRS symbol
- comb_off  in  1  DMRS comb offset (delta)
- dmrs_i, dmrs_q  in  DMRS_W each, signed  DMRS sample
- dmrs_valid  in  1 / dmrs_ready  out  1  DMRS handshake
- data_i, data_q  in  DATA_W each, signed  data sample
- data_valid  in  1 / data_ready  out  1  data handshake
- wr_en  out  1  grid write strobe
- wr_sym  out  4  symbol index of the write
- wr_addr  out  11  subcarrier index of the write
- wr_i, wr_q  out  DATA_W each, signed  grid write value
- sym_done  out  1  pulse on the last write of each symbol
- re_done  out  1  pulse on the last write of the allocation
- cfg_err  out  1  pulse when the configuration is rejected
- busy  out  1  high from CHECK through the last write

## Operation
- FSM states and transitions:
  - IDLE: waits for start.
  - CHECK: IDLE -> CHECK on start.
  - MAP_DMRS or MAP_DATA: CHECK goes to one of these, chosen by dmrs_mask[sym].
  - After the last RE of a symbol: sym increments and the next state is MAP_DMRS or MAP_DATA again. After sym_end the FSM returns to IDLE.
- CHECK rejects the configuration on any of:
  - n_rb==0
  - sym_start>sym_end
  - sym_end>=SYM_N
  - n_sc + 12*n_rb - 1 >= MAX_SC (computed at 12 bits, no wrap)
  
  On reject: cfg_err pulses, no writes are made, and the FSM returns to IDLE.
- RE counter k runs 0 .. 12*n_rb-1 per symbol; wr_addr = n_sc + k.
- MAP_DMRS, RE where k[0]==comb_off: the RE is a DMRS RE.
  - dmrs_ready=1.
  - The RE issues on dmrs_valid.
  - wr_i/wr_q = sign-extended dmrs_i/dmrs_q.
- MAP_DMRS, other REs: zero REs, handled per RE_ZERO_FILL_EN. dmrs_ready=0.
- MAP_DATA: every RE is a data RE. data_ready=1; the RE issues on data_valid.
- ready outputs are decoded from state and k only, never from valid. At most one ready is high in any cycle.
- start while busy is ignored. dmrs_valid/data_valid outside their ready windows are ignored, with no consumption.
- DMRS count consumed per DMRS symbol = 6*n_rb.

## Timing
- Reset values:
  - state IDLE, k=0
  - wr_en=0, wr_sym=0, wr_addr=0, wr_i=wr_q=0
  - all ready, done, err and busy outputs = 0
- A synchronous reset mid-allocation aborts on the next edge: no further writes, no done pulse.
- start at cycle 0 -> CHECK at cycle 1 -> first MAP cycle at cycle 2. cfg_err is asserted during cycle 2 on reject.
- Write latency is 1 cycle. An RE issued at cycle t gives wr_en=1 with its data at t+1.
- Zero REs issue unconditionally, one per cycle.
- Full throughput is 1 RE/cycle. The next symbol starts the cycle after the last RE issues, with no bubble.
- sym_done and re_done are coincident with the wr_en of the corresponding final write.

## Configuration
- RE_ZERO_FILL_EN defined: non-DMRS REs of a DMRS symbol issue as writes with wr_i=wr_q=0.
- RE_ZERO_FILL_EN undefined: those REs are skipped with no write. k advances by 2 per DMRS RE, and each DMRS symbol takes 6*n_rb issue cycles.
- Address and sym_done/re_done rules are identical in both builds.

## Structure
- re_mapper_pkg holds:
  - state enum (IDLE, CHECK, MAP_DMRS, MAP_DATA)
  - SC_PER_RB=12
  - default MAX_SC and SYM_N
  - configuration-check function
- Sub-module re_sc_counter holds the k counter, the last-RE compare and the comb decode, with inputs n_rb, comb_off, step and advance. The top level holds the FSM, the symbol counter and the output registers.

## Test plan
- n_sc=0, n_rb=1, sym 2..3, mask bit2 only, comb_off=0, zero-fill on:
  - Symbol 2: 12 writes at addr 0..11; even addresses carry DMRS and odd addresses carry 0.
  - Symbol 3: 12 data writes.
  - sym_done pulses twice, re_done once; 24 writes total.
- Same stimulus with zero-fill off: symbol 2 gives 6 writes at addr 0,2..10; comb_off=1 gives addr 1,3..11.
- data_valid toggled 1-0-1, n_rb=2: writes occur only after handshakes, addresses stay contiguous n_sc..n_sc+23, data order is preserved.
- n_sc=1190, n_rb=1: cfg_err=1 at cycle 2, no wr_en. Also sym_start=5, sym_end=4 -> cfg_err.
- Synchronous reset asserted mid-symbol: outputs are 0 on the next edge, no re_done. A subsequent start runs normally.
- start pulsed while busy: ignored, and the allocation completes unchanged.

Source files
------------

// File: rtl/re_mapper_gen_pkg.sv
// re_mapper_pkg: shared types and constants for the PUSCH RE mapper.
//   state_t   - mapper FSM states
//   SC_PER_RB - subcarriers per resource block
//   DEF_*     - default grid dimensions
//   cfg_ok()  - configuration acceptance check performed in CHECK
package re_mapper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    MAP_DMRS = 2'd2,
    MAP_DATA = 2'd3
  } state_t;

  localparam int unsigned SC_PER_RB  = 12;
  localparam int unsigned DEF_MAX_SC = 1200;
  localparam int unsigned DEF_SYM_N  = 14;

  // Last allocated subcarrier is formed at 12 bits: 2047 + 12*127 - 1 cannot wrap.
  function automatic logic cfg_ok(input logic [10:0] n_sc,
                                  input logic [6:0]  n_rb,
                                  input logic [3:0]  sym_start,
                                  input logic [3:0]  sym_end,
                                  input int unsigned sym_n,
                                  input int unsigned max_sc);
    logic [11:0] last_sc;
    last_sc = 12'(n_sc) + 12'(n_rb) * 12'(SC_PER_RB) - 12'd1;
    return (n_rb != '0) &&
           (sym_start <= sym_end) &&
           (32'(sym_end) < sym_n) &&
           (32'(last_sc) < max_sc);
  endfunction

endpackage

// File: rtl/re_mapper_gen_sc_counter.sv
// re_sc_counter: per-symbol RE counter k for the RE mapper.
//   CLK_RE, RST_RE  - clock, synchronous active-low reset
//   n_rb, comb_off  - latched allocation size and DMRS comb offset
//   load, load_lsb  - restart k at {0, load_lsb} for a new symbol
//   step            - 0: k advances by 1, 1: k advances by 2
//   advance         - an RE issued this cycle
//   k               - current RE index within the symbol
//   k_last          - the current RE is the last one of the symbol
//   is_dmrs         - the current RE sits on the DMRS comb
module re_sc_counter
  import re_mapper_pkg::*;
(
  input  logic        CLK_RE,
  input  logic        RST_RE,
  input  logic [6:0]  n_rb,
  input  logic        comb_off,
  input  logic        load,
  input  logic        load_lsb,
  input  logic        step,
  input  logic        advance,
  output logic [10:0] k,
  output logic        k_last,
  output logic        is_dmrs
);

  logic [11:0] re_total;
  logic [11:0] k_next;

  assign re_total = 12'(n_rb) * 12'(SC_PER_RB);
  assign k_next   = {1'b0, k} + (step ? 12'd2 : 12'd1);
  // With a step of 2 the last visited k is the final comb position, not re_total-1.
  assign k_last   = (k_next >= re_total);
  assign is_dmrs  = (k[0] == comb_off);

  always_ff @(posedge CLK_RE) begin
    if (!RST_RE) begin
      k <= '0;
    end else if (load) begin
      k <= {10'd0, load_lsb};
    end else if (advance) begin
      k <= k_next[10:0];
    end
  end

endmodule

// File: rtl/re_mapper_gen.sv
// re_mapper_gen: PUSCH resource-element mapper. Maps a DMRS stream and a
// data stream into the frequency grid over symbols sym_start..sym_end.
//   CLK_RE, RST_RE           - clock, synchronous active-low reset
//   start + cfg inputs       - n_sc, n_rb, sym_start, sym_end, dmrs_mask, comb_off
//   dmrs_* / data_*          - valid/ready sample streams
//   wr_en/wr_sym/wr_addr/wr_i/wr_q - registered grid write port
//   sym_done, re_done        - coincident with the final write of a symbol / allocation
//   cfg_err                  - configuration rejected
//   busy                     - CHECK through the last write
// Build option: RE_ZERO_FILL_EN defined writes zeros on non-DMRS REs of a
// DMRS symbol; undefined skips them (k steps over the comb).
module re_mapper_gen
  import re_mapper_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DMRS_W = 9,
  parameter int unsigned MAX_SC = DEF_MAX_SC,
  parameter int unsigned SYM_N  = DEF_SYM_N
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     start,
  input  logic [10:0]              n_sc,
  input  logic [6:0]               n_rb,
  input  logic [3:0]               sym_start,
  input  logic [3:0]               sym_end,
  input  logic [SYM_N-1:0]         dmrs_mask,
  input  logic                     comb_off,
  input  logic signed [DMRS_W-1:0] dmrs_i,
  input  logic signed [DMRS_W-1:0] dmrs_q,
  input  logic                     dmrs_valid,
  output logic                     dmrs_ready,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic signed [DATA_W-1:0] data_q,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     wr_en,
  output logic [3:0]               wr_sym,
  output logic [10:0]              wr_addr,
  output logic signed [DATA_W-1:0] wr_i,
  output logic signed [DATA_W-1:0] wr_q,
  output logic                     sym_done,
  output logic                     re_done,
  output logic                     cfg_err,
  output logic                     busy
);

`ifdef RE_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  state_t      state;
  logic [10:0] n_sc_q;
  logic [6:0]  n_rb_q;
  logic [3:0]  sym_start_q;
  logic [3:0]  sym_end_q;
  logic [15:0] mask_q;
  logic        comb_q;
  logic [3:0]  sym;

  logic        issue;
  logic        ctr_load;
  logic        ctr_lsb;
  logic        ctr_step;
  logic [10:0] k;
  logic        k_last;
  logic        is_dmrs;
  logic [3:0]  sym_nxt;
  logic        nxt_dmrs;
  logic [DATA_W-1:0] dmrs_i_ext;
  logic [DATA_W-1:0] dmrs_q_ext;

  assign dmrs_i_ext = {{(DATA_W-DMRS_W){dmrs_i[DMRS_W-1]}}, dmrs_i};
  assign dmrs_q_ext = {{(DATA_W-DMRS_W){dmrs_q[DMRS_W-1]}}, dmrs_q};

  assign dmrs_ready = (state == MAP_DMRS) && is_dmrs;
  assign data_ready = (state == MAP_DATA);
  // The final write lands one cycle after the FSM is already back in IDLE.
  assign busy       = (state != IDLE) || wr_en;

  always_comb begin
    issue = 1'b0;
    case (state)
      MAP_DMRS: issue = is_dmrs ? dmrs_valid : 1'b1;
      MAP_DATA: issue = data_valid;
      default:  issue = 1'b0;
    endcase
  end

  // Symbol entered next: the first one from CHECK, otherwise sym+1.
  assign sym_nxt  = (state == CHECK) ? sym_start_q : sym + 4'd1;
  assign nxt_dmrs = mask_q[sym_nxt];
  assign ctr_step = !ZERO_FILL && (state == MAP_DMRS);
  assign ctr_lsb  = !ZERO_FILL && nxt_dmrs && comb_q;
  assign ctr_load = (state == CHECK) || (issue && k_last && (sym != sym_end_q));

  re_sc_counter u_sc_counter (
    .CLK_RE   (CLK_RE),
    .RST_RE   (RST_RE),
    .n_rb     (n_rb_q),
    .comb_off (comb_q),
    .load     (ctr_load),
    .load_lsb (ctr_lsb),
    .step     (ctr_step),
    .advance  (issue),
    .k        (k),
    .k_last   (k_last),
    .is_dmrs  (is_dmrs)
  );

  always_ff @(posedge CLK_RE) begin
    if (!RST_RE) begin
      state       <= IDLE;
      n_sc_q      <= '0;
      n_rb_q      <= '0;
      sym_start_q <= '0;
      sym_end_q   <= '0;
      mask_q      <= '0;
      comb_q      <= 1'b0;
      sym         <= '0;
      wr_en       <= 1'b0;
      wr_sym      <= '0;
      wr_addr     <= '0;
      wr_i        <= '0;
      wr_q        <= '0;
      sym_done    <= 1'b0;
      re_done     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      sym_done <= 1'b0;
      re_done  <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !wr_en) begin
            n_sc_q      <= n_sc;
            n_rb_q      <= n_rb;
            sym_start_q <= sym_start;
            sym_end_q   <= sym_end;
            mask_q      <= 16'(dmrs_mask);
            comb_q      <= comb_off;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_ok(n_sc_q, n_rb_q, sym_start_q, sym_end_q, SYM_N, MAX_SC)) begin
            sym   <= sym_start_q;
            state <= nxt_dmrs ? MAP_DMRS : MAP_DATA;
          end else begin
            cfg_err <= 1'b1;
            state   <= IDLE;
          end
        end
        MAP_DMRS, MAP_DATA: begin
          if (issue) begin
            wr_en   <= 1'b1;
            wr_sym  <= sym;
            wr_addr <= n_sc_q + k;
            if (state == MAP_DATA) begin
              wr_i <= data_i;
              wr_q <= data_q;
            end else if (is_dmrs) begin
              wr_i <= dmrs_i_ext;
              wr_q <= dmrs_q_ext;
            end else begin
              wr_i <= '0;
              wr_q <= '0;
            end
            if (k_last) begin
              sym_done <= 1'b1;
              if (sym == sym_end_q) begin
                re_done <= 1'b1;
                state   <= IDLE;
              end else begin
                sym   <= sym_nxt;
                state <= nxt_dmrs ? MAP_DMRS : MAP_DATA;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_re_mapper_gen.sv
// Bench for re_mapper_gen: table of allocations plus random allocations,
// each checked write-by-write against an allocation-level reference model.
module tb_re_mapper_gen;

  localparam int DATA_W = 18;
  localparam int DMRS_W = 9;
`ifdef RE_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                     CLK_RE = 1'b0;
  logic                     RST_RE = 1'b0;
  logic                     start = 1'b0;
  logic [10:0]              n_sc = '0;
  logic [6:0]               n_rb = '0;
  logic [3:0]               sym_start = '0;
  logic [3:0]               sym_end = '0;
  logic [13:0]              dmrs_mask = '0;
  logic                     comb_off = 1'b0;
  logic signed [DMRS_W-1:0] dmrs_i = '0;
  logic signed [DMRS_W-1:0] dmrs_q = '0;
  logic                     dmrs_valid = 1'b0;
  logic                     dmrs_ready;
  logic signed [DATA_W-1:0] data_i = '0;
  logic signed [DATA_W-1:0] data_q = '0;
  logic                     data_valid = 1'b0;
  logic                     data_ready;
  logic                     wr_en;
  logic [3:0]               wr_sym;
  logic [10:0]              wr_addr;
  logic signed [DATA_W-1:0] wr_i;
  logic signed [DATA_W-1:0] wr_q;
  logic                     sym_done;
  logic                     re_done;
  logic                     cfg_err;
  logic                     busy;

  re_mapper_gen #(.DATA_W(DATA_W), .DMRS_W(DMRS_W), .MAX_SC(1200), .SYM_N(14)) dut (
    .CLK_RE(CLK_RE), .RST_RE(RST_RE), .start(start), .n_sc(n_sc), .n_rb(n_rb),
    .sym_start(sym_start), .sym_end(sym_end), .dmrs_mask(dmrs_mask), .comb_off(comb_off),
    .dmrs_i(dmrs_i), .dmrs_q(dmrs_q), .dmrs_valid(dmrs_valid), .dmrs_ready(dmrs_ready),
    .data_i(data_i), .data_q(data_q), .data_valid(data_valid), .data_ready(data_ready),
    .wr_en(wr_en), .wr_sym(wr_sym), .wr_addr(wr_addr), .wr_i(wr_i), .wr_q(wr_q),
    .sym_done(sym_done), .re_done(re_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 CLK_RE = ~CLK_RE;

  typedef struct packed {
    logic [3:0]  sym;
    logic [10:0] addr;
    logic [17:0] i;
    logic [17:0] q;
    logic        sd;
    logic        rd;
  } wr_t;

  typedef struct {
    logic [10:0] n_sc;
    logic [6:0]  n_rb;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [13:0] mask;
    logic        comb;
    int          vmode;   // 0 always valid, 1 random, 2 toggle 1-0-1, 3 off
    int          exp_err;
  } vec_t;

  wr_t exp_q[$];
  wr_t act_q[$];
  logic signed [8:0]  dpi[2048];
  logic signed [8:0]  dpq[2048];
  logic signed [17:0] xi[2048];
  logic signed [17:0] xq[2048];

  int   dptr, xptr, cycle, vmode;
  int   checks = 0;
  int   errors = 0;
  int   first_wr_cycle, last_rd_cycle, err_cycle, err_cnt, sd_cnt, rd_cnt;
  int   overlap = 0;
  logic busy_c1;
  bit   dhs, xhs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int sc, int rb, int s0, int s1, int mask, int comb, int vm, int err);
    vec_t v;
    v.n_sc = 11'(sc); v.n_rb = 7'(rb); v.s0 = 4'(s0); v.s1 = 4'(s1);
    v.mask = 14'(mask); v.comb = 1'(comb); v.vmode = vm; v.exp_err = err;
    return v;
  endfunction

  function automatic bit vgen(int mode, int c);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (c % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive();
    dmrs_valid = vgen(vmode, cycle);
    data_valid = vgen(vmode, cycle);
    dmrs_i = dpi[dptr & 2047];
    dmrs_q = dpq[dptr & 2047];
    data_i = xi[xptr & 2047];
    data_q = xq[xptr & 2047];
  endtask

  // One clock: note handshakes offered this cycle, then sample after the edge.
  task automatic cyc();
    dhs = dmrs_valid && dmrs_ready && RST_RE;
    xhs = data_valid && data_ready && RST_RE;
    if (dmrs_ready && data_ready) overlap++;
    @(posedge CLK_RE);
    #1;
    cycle++;
    if (dhs) dptr++;
    if (xhs) xptr++;
    if (wr_en) begin
      act_q.push_back({wr_sym, wr_addr, wr_i, wr_q, sym_done, re_done});
      if (first_wr_cycle < 0) first_wr_cycle = cycle;
    end
    if (sym_done) sd_cnt++;
    if (re_done) begin rd_cnt++; last_rd_cycle = cycle; end
    if (cfg_err) begin err_cnt++; err_cycle = cycle; end
    if (cycle == 1) busy_c1 = busy;
    start = 1'b0;
    drive();
  endtask

  // Reference: walk the allocation RE by RE, consuming each stream in order.
  // Returns the number of issue cycles the allocation needs at full rate.
  function automatic int build_exp(vec_t v);
    int  n, ic, dp, xp;
    wr_t sym_w[$];
    exp_q.delete();
    ic = 0; dp = 0; xp = 0;
    if (v.n_rb == 0 || v.s0 > v.s1 || v.s1 >= 14 ||
        int'(v.n_sc) + 12 * int'(v.n_rb) - 1 >= 1200) return 0;
    n = 12 * int'(v.n_rb);
    for (int s = int'(v.s0); s <= int'(v.s1); s++) begin
      sym_w.delete();
      for (int k = 0; k < n; k++) begin
        wr_t w;
        logic signed [17:0] ei, eq;
        w = '0;
        w.sym  = 4'(s);
        w.addr = 11'(int'(v.n_sc) + k);
        if (v.mask[s]) begin
          if ((k % 2) == int'(v.comb)) begin
            ei = dpi[dp]; eq = dpq[dp]; dp++;
            w.i = ei; w.q = eq;
            sym_w.push_back(w); ic++;
          end else if (ZF) begin
            sym_w.push_back(w); ic++;
          end
        end else begin
          w.i = xi[xp]; w.q = xq[xp]; xp++;
          sym_w.push_back(w); ic++;
        end
      end
      sym_w[$].sd = 1'b1;
      if (s == int'(v.s1)) sym_w[$].rd = 1'b1;
      foreach (sym_w[j]) exp_q.push_back(sym_w[j]);
    end
    return ic;
  endfunction

  task automatic clear_stats();
    act_q.delete();
    dptr = 0; xptr = 0; cycle = 0;
    first_wr_cycle = -1; last_rd_cycle = -1; err_cycle = -1;
    err_cnt = 0; sd_cnt = 0; rd_cnt = 0; busy_c1 = 1'b0;
  endtask

  task automatic run_alloc(input vec_t v, input int poke, input string tag);
    int  ic, budget, nsym;
    bit  done;
    clear_stats();
    for (int i = 0; i < 2048; i++) begin
      dpi[i] = 9'($urandom); dpq[i] = 9'($urandom);
      xi[i] = 18'($urandom); xq[i] = 18'($urandom);
    end
    ic = build_exp(v);
    vmode = v.vmode;
    n_sc = v.n_sc; n_rb = v.n_rb; sym_start = v.s0; sym_end = v.s1;
    dmrs_mask = v.mask; comb_off = v.comb;
    drive();
    start = 1'b1;
    budget = 8 * exp_q.size() + 60;
    done = 1'b0;
    while (!done && cycle < budget) begin
      if (poke > 0 && cycle == poke) begin
        start = 1'b1; n_sc = 11'd500; n_rb = 7'd3; sym_start = 4'd0; sym_end = 4'd13;
        dmrs_mask = 14'h3fff; comb_off = ~v.comb;
      end
      cyc();
      if (rd_cnt > 0 || err_cnt > 0) done = 1'b1;
    end
    chk({tag, " finished_in_budget"}, 64'(done), 64'd1);
    repeat (4) cyc();
    nsym = v.exp_err ? 0 : int'(v.s1) - int'(v.s0) + 1;
    chk({tag, " cfg_err_count"}, 64'(err_cnt), 64'(v.exp_err));
    if (v.exp_err != 0) chk({tag, " cfg_err_cycle"}, 64'(err_cycle), 64'd2);
    chk({tag, " busy_in_check"}, 64'(busy_c1), 64'd1);
    chk({tag, " write_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s wr%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    chk({tag, " sym_done_count"}, 64'(sd_cnt), 64'(nsym));
    chk({tag, " re_done_count"}, 64'(rd_cnt), 64'(v.exp_err ? 0 : 1));
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    if (v.vmode == 0 && v.exp_err == 0) begin
      chk({tag, " first_write_cycle"}, 64'(first_wr_cycle), 64'd3);
      chk({tag, " last_write_cycle"}, 64'(last_rd_cycle), 64'(2 + ic));
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(0,    1,   2, 3,  'h0004, 0, 0, 0);
    tbl[1]  = mk(0,    1,   2, 3,  'h0004, 1, 0, 0);
    tbl[2]  = mk(100,  2,   0, 0,  'h0000, 0, 2, 0);
    tbl[3]  = mk(1190, 1,   0, 0,  'h0000, 0, 0, 1);
    tbl[4]  = mk(1188, 1,   13, 13, 'h2000, 1, 1, 0);
    tbl[5]  = mk(10,   1,   5, 4,  'h0000, 0, 0, 1);
    tbl[6]  = mk(10,   0,   0, 0,  'h0000, 0, 0, 1);
    tbl[7]  = mk(10,   1,   0, 14, 'h0000, 0, 0, 1);
    tbl[8]  = mk(1,    100, 0, 0,  'h0000, 0, 0, 1);
    tbl[9]  = mk(0,    100, 0, 0,  'h0001, 0, 0, 0);
    tbl[10] = mk(37,   3,   0, 13, 'h0891, 1, 1, 0);

    // Reset state
    vmode = 3;
    clear_stats();
    drive();
    repeat (3) cyc();
    chk("reset_outputs",
        64'({wr_en, wr_sym, wr_addr, wr_i, wr_q, sym_done, re_done, cfg_err, busy,
             dmrs_ready, data_ready}), 64'd0);
    RST_RE = 1'b1;
    cyc();
    chk("idle_after_reset", 64'({wr_en, busy, dmrs_ready, data_ready}), 64'd0);

    // Hand-derived write counts for the basic DMRS + data case
    run_alloc(tbl[0], 0, "t0");
    chk("t0_writes_hand", 64'(act_q.size()), 64'(ZF ? 24 : 18));
    if (act_q.size() > 1) chk("t0_second_addr", 64'(act_q[1].addr), 64'(ZF ? 1 : 2));

    for (int t = 1; t < 11; t++) run_alloc(tbl[t], 0, $sformatf("t%0d", t));

    // Synchronous reset in the middle of a symbol
    clear_stats();
    vmode = 0;
    n_sc = 11'd0; n_rb = 7'd4; sym_start = 4'd0; sym_end = 4'd1;
    dmrs_mask = '0; comb_off = 1'b0;
    drive();
    start = 1'b1;
    repeat (8) cyc();
    chk("writes_before_reset", 64'(act_q.size()), 64'd6);
    RST_RE = 1'b0;
    cyc();
    chk("outputs_after_mid_reset",
        64'({wr_en, wr_sym, wr_addr, wr_i, wr_q, sym_done, re_done, cfg_err, busy,
             dmrs_ready, data_ready}), 64'd0);
    RST_RE = 1'b1;
    act_q.delete(); rd_cnt = 0;
    repeat (60) cyc();
    chk("no_write_after_reset", 64'(act_q.size()), 64'd0);
    chk("no_re_done_after_reset", 64'(rd_cnt), 64'd0);
    run_alloc(mk(5, 2, 0, 1, 'h0001, 1, 0, 0), 0, "post_reset");

    // start pulsed while busy must be ignored
    run_alloc(mk(20, 2, 1, 2, 'h0002, 0, 0, 0), 6, "start_busy");

    // Random allocations with random valid
    for (int r = 0; r < 6; r++) begin
      int rb, s0;
      rb = $urandom_range(1, 8);
      s0 = $urandom_range(0, 13);
      run_alloc(mk($urandom_range(0, 1200 - 12 * rb), rb, s0, $urandom_range(s0, 13),
                   $urandom_range(0, 16383), $urandom_range(0, 1), 1, 0),
                0, $sformatf("rnd%0d", r));
    end

    chk("ready_overlap", 64'(overlap), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
